instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of decoder_v2. It replaces the simple next_instr-driven instruction memory hookup. A program counter drives a synchronous-read instruction memory port. Returned words are buffered in a small prefetch FIFO and presented to the decoder as instr/instr_valid; the decoder's next_instr pulse pops one entry. A redirect input flushes the FIFO, discards any in-flight read and restarts fetch at a new PC.

---
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencer driving a synchronous-read imem port, plus a prefetch FIFO feeding the decoder.
// Optional macro FETCH_ALIGN_CHK_EN: misaligned redirects are rejected and flagged on a sticky fetch_misalign output.
module instr_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            next_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic            fetch_misalign
`endif
);
    localparam int unsigned     PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned     CW        = PW + 1;
    localparam logic [CW:0]     DEPTH_OCC = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_take;
    logic            push;
    logic            pop;

`ifdef FETCH_ALIGN_CHK_EN
    assign redirect_take = redirect_valid && (state != IDLE) && (redirect_pc[1:0] == 2'b00);
`else
    assign redirect_take = redirect_valid && (state != IDLE);
`endif

    assign redirect_target = redirect_pc & ~XLEN'(3);
    // Reserve a FIFO slot for the read in flight so a returning word always has room.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req    = (state == RUN) && !redirect_take && (occupancy < DEPTH_OCC);
    assign imem_addr   = pc & ~XLEN'(3);
    assign push        = inflight && !redirect_take;
    assign pop         = next_instr && instr_valid && !redirect_take;
    assign instr_valid = (count != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fifo_instr  <= '{default: '0};
            fifo_pc     <= '{default: '0};
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= imem_addr;
            end
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= inflight_pc;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);

            case (state)
                IDLE:    state <= RUN;
                RUN:     state <= RUN;
                FLUSH:   state <= RUN;
                default: state <= IDLE;
            endcase

            // Redirect overrides everything above: flush, drop any response, restart at the new PC.
            if (redirect_take) begin
                state  <= FLUSH;
                pc     <= redirect_target;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end

            assert (!(push && !pop && (count == DEPTH_CNT)));
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (reset)
            fetch_misalign <= 1'b0;
        else if (redirect_valid && (state != IDLE) && (redirect_pc[1:0] != 2'b00))
            fetch_misalign <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: request addresses and presented instructions are checked against a PC scoreboard.
// A second instance with RESET_PC near the top of the address space covers PC wrap.
module tb_instr_fetch;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            next_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            w_imem_req;
    logic [XLEN-1:0] w_imem_addr;
    logic [XLEN-1:0] w_imem_rdata;
    logic [XLEN-1:0] w_instr;
    logic [XLEN-1:0] w_instr_pc;
    logic            w_instr_valid;
`ifdef FETCH_ALIGN_CHK_EN
    logic            fetch_misalign;
    logic            w_fetch_misalign;
`endif

    int unsigned     checks   = 0;
    int unsigned     failures = 0;
    logic [31:0]     exp_q [$];
    logic [31:0]     exp_addr;
    logic [31:0]     exp_pc;

    instr_fetch #(.XLEN(XLEN), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .next_instr(next_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_ALIGN_CHK_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    instr_fetch #(.XLEN(XLEN), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
        .next_instr(1'b1), .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_ALIGN_CHK_EN
        , .fetch_misalign(w_fetch_misalign)
`endif
    );

    // Data differs from the address so swapped instr/instr_pc is visible; junk when no request was made.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) begin
        imem_rdata   <= (imem_req === 1'b1) ? mem_word(imem_addr) : $urandom();
        w_imem_rdata <= (w_imem_req === 1'b1) ? mem_word(w_imem_addr) : $urandom();
    end

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_addr = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; next_instr = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        checks++; if (w_imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL reset_wrap_addr: got %h want fffffff8", w_imem_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_stream(input string tag);
        do_reset();
        next_instr = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== (c != 0)) begin failures++; $display("FAIL %s_req cycle %0d: got %b want %b", tag, c, imem_req, (c != 0)); end
            checks++;
            if (instr_valid !== (c >= 3)) begin failures++; $display("FAIL %s_valid cycle %0d: got %b want %b", tag, c, instr_valid, (c >= 3)); end
            if (imem_req === 1'b1) begin
                checks++;
                if (imem_addr !== exp_addr) begin failures++; $display("FAIL %s_addr cycle %0d: got %h want %h", tag, c, imem_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 32'd4;
            end
            if (instr_valid === 1'b1 && next_instr === 1'b1) begin
                if (exp_q.size() > 0) exp_pc = exp_q.pop_front(); else exp_pc = 32'hDEAD_BEEF;
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin failures++;
                    $display("FAIL %s_instr cycle %0d: got pc=%h instr=%h want pc=%h instr=%h", tag, c, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset();
        next_instr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                nreq++;
                checks++;
                if (imem_addr !== exp_addr) begin failures++; $display("FAIL bp_addr cycle %0d: got %h want %h", c, imem_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 32'd4;
            end
            @(posedge clk); #1;
        end
        next_instr = 1'b1;
        @(negedge clk);
        checks++; if (nreq != 4) begin failures++; $display("FAIL bp_nreq: got %0d want 4", nreq); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_full_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_full_valid: got %b want 1", instr_valid); end
        if (exp_q.size() > 0) exp_pc = exp_q.pop_front(); else exp_pc = 32'hDEAD_BEEF;
        checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL bp_head: got %h want %h", instr_pc, exp_pc); end
        @(posedge clk); #1;
        next_instr = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++;
            $display("FAIL bp_refill: got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr); end
        exp_q.push_back(exp_addr); exp_addr += 32'd4;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_single_refill: got %b want 0", imem_req); end
        @(posedge clk); #1;
    endtask

    // Continues from the full FIFO left by test_backpressure, with a random pop pattern.
    task automatic test_back_to_back();
        for (int c = 0; c < 80; c++) begin
            next_instr = (c < 8) ? 1'b1 : ($urandom_range(3) != 0);
            @(negedge clk);
            if (imem_req === 1'b1) begin
                checks++;
                if (imem_addr !== exp_addr) begin failures++; $display("FAIL b2b_addr cycle %0d: got %h want %h", c, imem_addr, exp_addr); end
                exp_q.push_back(exp_addr); exp_addr += 32'd4;
            end
            if (instr_valid === 1'b1 && next_instr === 1'b1) begin
                if (exp_q.size() > 0) exp_pc = exp_q.pop_front(); else exp_pc = 32'hDEAD_BEEF;
                checks++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin failures++;
                    $display("FAIL b2b_instr cycle %0d: got pc=%h instr=%h want pc=%h instr=%h", c, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        next_instr = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_idle_req: got %b want 0", imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++;
            $display("FAIL redir_idle_ignored: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
        exp_q.push_back(exp_addr); exp_addr += 32'd4;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (imem_req === 1'b1) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
            @(posedge clk); #1;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100; next_instr = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL redir_pre_valid: got %b want 1", instr_valid); end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        exp_q.delete(); exp_addr = 32'h100;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++;
            $display("FAIL redir_flush: got valid=%b req=%b want valid=0 req=0", instr_valid, imem_req); end
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (imem_req === 1'b1) begin
                    checks++;
                    if (imem_addr !== exp_addr) begin failures++; $display("FAIL redir_addr r%0d cycle %0d: got %h want %h", r, c, imem_addr, exp_addr); end
                    exp_q.push_back(exp_addr); exp_addr += 32'd4;
                end
                if (instr_valid === 1'b1 && next_instr === 1'b1) begin
                    if (exp_q.size() > 0) exp_pc = exp_q.pop_front(); else exp_pc = 32'hDEAD_BEEF;
                    checks++;
                    if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin failures++;
                        $display("FAIL redir_instr r%0d cycle %0d: got pc=%h instr=%h want pc=%h", r, c, instr_pc, instr, exp_pc); end
                end
                @(posedge clk); #1;
            end
            if (r == 0) begin
                // Second redirect lands while the first one's FLUSH cycle is active.
                redirect_valid = 1'b1; redirect_pc = 32'h400;
                @(negedge clk);
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir2_req: got %b want 0", imem_req); end
                @(posedge clk); #1;
                redirect_pc = 32'h500;
                @(negedge clk);
                checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++;
                    $display("FAIL redir2_flush: got valid=%b req=%b want 0 0", instr_valid, imem_req); end
                @(posedge clk); #1;
                redirect_valid = 1'b0;
                exp_q.delete(); exp_addr = 32'h500;
                @(negedge clk);
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir2_restart_req: got %b want 0", imem_req); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        next_instr = 1'b1;
        for (int c = 0; c < 14; c++) begin
            redirect_valid = (c == 6);
            redirect_pc = 32'h0000_0102;
            @(negedge clk);
`ifdef FETCH_ALIGN_CHK_EN
            checks++;
            if (fetch_misalign !== (c > 6)) begin failures++; $display("FAIL misalign_flag cycle %0d: got %b want %b", c, fetch_misalign, (c > 6)); end
            begin
`else
            if (c == 6) begin
                checks++;
                if (imem_req !== 1'b0) begin failures++; $display("FAIL misalign_redir_req: got %b want 0", imem_req); end
                exp_q.delete(); exp_addr = 32'h100;
            end else begin
`endif
                if (imem_req === 1'b1) begin
                    checks++;
                    if (imem_addr !== exp_addr) begin failures++; $display("FAIL misalign_addr cycle %0d: got %h want %h", c, imem_addr, exp_addr); end
                    exp_q.push_back(exp_addr); exp_addr += 32'd4;
                end
                if (instr_valid === 1'b1 && next_instr === 1'b1) begin
                    if (exp_q.size() > 0) exp_pc = exp_q.pop_front(); else exp_pc = 32'hDEAD_BEEF;
                    checks++;
                    if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin failures++;
                        $display("FAIL misalign_instr cycle %0d: got pc=%h instr=%h want pc=%h", c, instr_pc, instr, exp_pc); end
                end
            end
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_pc_wrap();
        logic [31:0] want;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (w_imem_req !== (c != 0)) begin failures++; $display("FAIL wrap_req cycle %0d: got %b want %b", c, w_imem_req, (c != 0)); end
            if (c >= 1) begin
                want = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
                checks++;
                if (w_imem_addr !== want) begin failures++; $display("FAIL wrap_addr cycle %0d: got %h want %h", c, w_imem_addr, want); end
            end
            checks++;
            if (w_instr_valid !== (c >= 3)) begin failures++; $display("FAIL wrap_valid cycle %0d: got %b want %b", c, w_instr_valid, (c >= 3)); end
            if (c >= 3) begin
                want = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
                checks++;
                if (w_instr_pc !== want || w_instr !== mem_word(want)) begin failures++;
                    $display("FAIL wrap_instr cycle %0d: got pc=%h instr=%h want pc=%h instr=%h", c, w_instr_pc, w_instr, want, mem_word(want)); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream("stream");
        test_backpressure();
        test_back_to_back();
        test_stream("midreset");
        test_redirect();
        test_misalign();
        test_reset_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
